la_ctrl_counter: RTL and testbench

LA-controlled 16-bit step counter in the user project area. The management core configures and starts it through the logic analyzer (LA) bus. The block drives its count onto `mprj_io[31:16]` as check bits for the testbench and reports status back on the LA input bus. It is the user-side stage that feeds the LA test bench's pin monitor.

---
 rtl/la_ctrl_counter.sv | 153 +++++++++++++++
 tb/tb_la_ctrl_counter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_ctrl_counter.sv
`default_nettype none
// ============================================================================
//  Module   : la_ctrl_counter
//  Purpose  : 16-bit step counter configured and started by the management
//             core over the logic analyzer bus. The count is driven onto
//             io_out[31:16]; status is returned on la_data_out.
//  Ports    : clock        - system clock
//             resetb       - synchronous active-low reset
//             la_data_in   - LA control/data from the management core
//             la_oenb      - LA per-bit enables (0 = core drives the bit)
//             la_data_out  - status: count, done, busy, load_err, state
//             io_out       - pad outputs, count on [31:16]
//             io_oeb       - pad output enables (active-low)
//             irq          - user interrupts, [0] pulses on target match
//  Revision : 1.0 - initial release
// ============================================================================
module la_ctrl_counter #(
    parameter int CNT_W = 16
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb,
    output logic [2:0]   irq
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_load_err;
    logic             r_irq;
    logic             r_strobe_d;
    // Low during reset and for the first cycle after it; enables the pads
    // and arms the load-strobe edge detector.
    logic             r_live;

    // A control bit only counts when the core actually drives it.
    logic [47:0]      w_ctl;
    logic             w_ld_full;
    logic             w_tgt_full;
    logic [CNT_W-1:0] w_ld_val;
    logic [CNT_W-1:0] w_tgt;
    logic             w_run;
    logic             w_dir_up;
    logic             w_clr;
    logic [3:0]       w_step4;
    logic [CNT_W-1:0] w_step;
    logic [CNT_W-1:0] w_next;
    logic             w_rise;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_hit;
    logic             w_busy;
    logic             w_unused;

    assign w_ctl      = la_data_in[47:0] & ~la_oenb[47:0];
    assign w_ld_full  = (la_oenb[CNT_W-1:0] == '0);
    assign w_tgt_full = (la_oenb[32 +: CNT_W] == '0);
    assign w_ld_val   = w_ctl[CNT_W-1:0];
    assign w_tgt      = w_ctl[32 +: CNT_W];
    assign w_run      = w_ctl[16];
    assign w_dir_up   = w_ctl[17];
    assign w_clr      = w_ctl[18];
    assign w_step4    = (w_ctl[23:20] == 4'd0) ? 4'd1 : w_ctl[23:20];
    assign w_step     = {{(CNT_W-4){1'b0}}, w_step4};
    assign w_next     = w_dir_up ? (r_count + w_step) : (r_count - w_step);

    // Gating with r_live keeps a strobe already high at reset release from
    // being mistaken for a fresh rising edge.
    assign w_rise     = r_live & w_ctl[19] & ~r_strobe_d;
    assign w_load_ok  = w_rise & w_ld_full;
    assign w_load_bad = w_rise & ~w_ld_full;
    assign w_hit      = w_tgt_full && (w_next == w_tgt);
    assign w_busy     = (r_state == c_ST_RUN);

    assign w_unused   = ^{la_data_in[127:48], la_oenb[127:48], w_ctl[31:24]};

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            r_irq      <= 1'b0;
            r_strobe_d <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            // Tracks the strobe even during clear so edges there are dropped.
            r_strobe_d <= w_ctl[19];
            r_irq      <= 1'b0;
            if (w_clr) begin
                r_state    <= c_ST_IDLE;
                r_count    <= '0;
                r_done     <= 1'b0;
                r_load_err <= 1'b0;
            end else begin
                if (w_load_bad) begin
                    r_load_err <= 1'b1;
                end
                if (w_load_ok) begin
                    r_state <= c_ST_LOAD;
                end else begin
                    case (r_state)
                        c_ST_IDLE: begin
                            if (w_run) begin
                                r_state <= c_ST_RUN;
                            end
                        end
                        c_ST_LOAD: begin
                            r_count <= w_ld_val;
                            r_done  <= 1'b0;
                            r_state <= w_run ? c_ST_RUN : c_ST_IDLE;
                        end
                        c_ST_RUN: begin
                            if (!w_run) begin
                                r_state <= c_ST_IDLE;
                            end else begin
                                r_count <= w_next;
                                if (w_hit) begin
                                    r_state <= c_ST_DONE;
                                    r_done  <= 1'b1;
                                    r_irq   <= 1'b1;
                                end
                            end
                        end
                        c_ST_DONE: begin
                            r_state <= c_ST_DONE;
                        end
                        default: begin
                            r_state <= c_ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign la_data_out = {{(128-CNT_W-5){1'b0}}, r_state, r_load_err, w_busy, r_done, r_count};
    assign io_out      = {6'b0, r_count, 16'b0};
    assign io_oeb      = r_live ? {6'h3F, {CNT_W{1'b0}}, 16'hFFFF} : {38{1'b1}};
    assign irq         = {2'b00, r_irq};

endmodule
`default_nettype wire

// File: tb/tb_la_ctrl_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_la_ctrl_counter
//  Purpose  : Self-checking bench for la_ctrl_counter. A cycle-level model of
//             the counter's rules is compared with the DUT every cycle, and
//             directed scenarios carry hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_la_ctrl_counter;

    logic         clock = 1'b0;
    logic         resetb;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;
    logic [2:0]   irq;

    int checks = 0;
    int errors = 0;
    int irq_pulses = 0;

    la_ctrl_counter #(.CNT_W(16)) dut (
        .clock       (clock),
        .resetb      (resetb),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .io_out      (io_out),
        .io_oeb      (io_oeb),
        .irq         (irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Model: mode 0 idle, 1 load, 2 run, 3 done (the reported state code).
    int m_count = 0;
    int m_mode  = 0;
    int m_age   = 0;
    bit m_done  = 0;
    bit m_err   = 0;
    bit m_irq   = 0;
    bit m_prev  = 0;
    bit m_valid = 0;

    always @(posedge clock) begin : model
        logic [47:0] ctl;
        bit          req;
        bit          ok;
        int          step;
        int          nxt;
        if (!resetb) begin
            m_count = 0; m_mode = 0; m_done = 0; m_err = 0;
            m_irq = 0; m_prev = 0; m_age = 0; m_valid = 1;
        end else begin
            ctl    = la_data_in[47:0] & ~la_oenb[47:0];
            req    = (m_age > 0) && ctl[19] && !m_prev;
            m_prev = ctl[19];
            if (m_age < 1000000) m_age++;
            ok     = req && (la_oenb[15:0] == 16'h0);
            m_irq  = 0;
            step   = int'(ctl[23:20]);
            if (step == 0) step = 1;
            if (ctl[18]) begin
                m_count = 0; m_done = 0; m_err = 0; m_mode = 0;
            end else begin
                if (req && !ok) m_err = 1;
                if (ok) begin
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    m_count = int'(ctl[15:0]);
                    m_done  = 0;
                    m_mode  = ctl[16] ? 2 : 0;
                end else if (m_mode == 0) begin
                    if (ctl[16]) m_mode = 2;
                end else if (m_mode == 2) begin
                    if (!ctl[16]) begin
                        m_mode = 0;
                    end else begin
                        nxt = ctl[17] ? (m_count + step) % 65536
                                      : (m_count - step + 65536) % 65536;
                        m_count = nxt;
                        if (la_oenb[47:32] == 16'h0 && nxt == int'(ctl[47:32])) begin
                            m_mode = 3; m_done = 1; m_irq = 1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [127:0] exp_la();
        logic [127:0] e;
        e        = '0;
        e[15:0]  = m_count[15:0];
        e[16]    = m_done;
        e[17]    = (m_mode == 2);
        e[18]    = m_err;
        e[20:19] = m_mode[1:0];
        return e;
    endfunction

    function automatic logic [37:0] exp_io();
        logic [37:0] e;
        e        = '0;
        e[31:16] = m_count[15:0];
        return e;
    endfunction

    function automatic logic [37:0] exp_oeb();
        logic [37:0] e;
        e = '1;
        if (m_age > 0) e[31:16] = 16'h0;
        return e;
    endfunction

    always @(posedge clock) begin : compare
        #1;
        if (m_valid) begin
            chk("model_la_data_out", la_data_out, exp_la());
            chk("model_io_out", io_out, exp_io());
            chk("model_io_oeb", io_oeb, exp_oeb());
            chk("model_irq", irq, {125'b0, m_irq});
        end
    end

    always @(negedge clock) begin
        if (irq[0] === 1'b1) irq_pulses++;
    end

    initial begin
        resetb     = 1'b0;
        la_oenb    = '1;
        la_data_in = '0;
        cyc(3);
        chk("rst_la_data_out", la_data_out, 128'h0);
        chk("rst_io_out", io_out, 38'h0);
        chk("rst_io_oeb", io_oeb, 38'h3FFFFFFFFF);
        chk("rst_irq", irq, 3'b000);
        resetb = 1'b1;
        cyc(100);
        chk("idle_la_data_out", la_data_out, 128'h0);
        chk("idle_io_out", io_out, 38'h0);
        chk("idle_io_oeb", io_oeb, 38'h3F0000FFFF);

        // Up-count 0x0010 -> 0x0014, step 1.
        la_oenb[47:0]     = '0;
        la_data_in[15:0]  = 16'h0010;
        la_data_in[47:32] = 16'h0014;
        la_data_in[17]    = 1'b1;
        la_data_in[23:20] = 4'd1;
        cyc(1);
        la_data_in[19] = 1'b1;
        cyc(1);
        chk("load_state", la_data_out[20:19], 2'd1);
        cyc(1);
        chk("load_count", la_data_out[20:0], 21'h000010);
        la_data_in[19] = 1'b0;
        la_data_in[16] = 1'b1;
        irq_pulses     = 0;
        cyc(2);
        chk("up_first_step", la_data_out[20:0], 21'h120011);
        cyc(3);
        chk("up_done_status", la_data_out[20:0], 21'h190014);
        chk("up_irq", irq, 3'b001);
        cyc(5);
        chk("up_hold", la_data_out[20:0], 21'h190014);
        chk("up_checkbits", io_out[31:16], 16'h0014);
        chk("irq_pulses", irq_pulses, 1);

        // Down-count from 0x0001, step 2, target 0xFFFB.
        la_data_in[16]    = 1'b0;
        la_data_in[17]    = 1'b0;
        la_data_in[23:20] = 4'd2;
        la_data_in[15:0]  = 16'h0001;
        la_data_in[47:32] = 16'hFFFB;
        la_data_in[19]    = 1'b1;
        cyc(1);
        chk("reload_from_done", la_data_out[20:16], 5'b01001);
        cyc(1);
        chk("down_loaded", la_data_out[20:0], 21'h000001);
        la_data_in[19] = 1'b0;
        la_data_in[16] = 1'b1;
        cyc(2);
        chk("down_wrap", la_data_out[20:0], 21'h12FFFF);
        cyc(2);
        chk("down_done", la_data_out[20:0], 21'h19FFFB);

        // Load value equal to target: no immediate done.
        la_data_in[16]    = 1'b0;
        la_data_in[17]    = 1'b1;
        la_data_in[23:20] = 4'd1;
        la_data_in[15:0]  = 16'h0004;
        la_data_in[47:32] = 16'h0004;
        la_data_in[19]    = 1'b1;
        cyc(2);
        chk("eq_loaded", la_data_out[20:0], 21'h000004);
        la_data_in[19] = 1'b0;
        la_data_in[16] = 1'b1;
        cyc(6);
        chk("eq_no_done", la_data_out[20:0], 21'h120009);

        // Target skipped by step 2 across the wrap; load wins over running.
        la_data_in[16]    = 1'b0;
        la_data_in[23:20] = 4'd2;
        la_data_in[15:0]  = 16'hFFF0;
        la_data_in[47:32] = 16'h0003;
        la_data_in[19]    = 1'b1;
        cyc(2);
        chk("skip_loaded", la_data_out[20:0], 21'h00FFF0);
        la_data_in[19] = 1'b0;
        la_data_in[16] = 1'b1;
        cyc(20);
        chk("skip_no_match", la_data_out[20:0], 21'h120016);

        // Load with partially driven load value sets sticky error.
        la_data_in[16] = 1'b0;
        cyc(1);
        chk("stop_hold", la_data_out[20:0], 21'h000016);
        la_oenb[15:0]  = 16'h00FF;
        la_data_in[19] = 1'b1;
        cyc(2);
        chk("load_err_set", la_data_out[20:0], 21'h040016);
        la_data_in[19] = 1'b0;
        la_data_in[18] = 1'b1;
        la_oenb[15:0]  = 16'h0000;
        cyc(2);
        chk("clear_all", la_data_out, 128'h0);

        // Clear and strobe rising together while running.
        la_data_in[18]   = 1'b0;
        la_data_in[15:0] = 16'h0100;
        la_data_in[16]   = 1'b1;
        cyc(4);
        chk("run_busy", la_data_out[17], 1'b1);
        la_data_in[18] = 1'b1;
        la_data_in[19] = 1'b1;
        la_data_in[16] = 1'b0;
        cyc(2);
        chk("clear_beats_load", la_data_out, 128'h0);
        la_data_in[18] = 1'b0;
        cyc(3);
        chk("held_strobe_after_clear", la_data_out, 128'h0);

        // Strobe held high across reset release does not load.
        resetb = 1'b0;
        cyc(2);
        chk("rst2_io_oeb", io_oeb, 38'h3FFFFFFFFF);
        resetb = 1'b1;
        cyc(3);
        chk("held_strobe_after_reset", la_data_out, 128'h0);

        // One-cycle reset in the middle of RUN.
        la_data_in[19] = 1'b0;
        la_data_in[16] = 1'b1;
        cyc(5);
        chk("pre_reset_busy", la_data_out[17], 1'b1);
        resetb = 1'b0;
        cyc(1);
        chk("midrun_reset", la_data_out, 128'h0);
        chk("midrun_reset_oeb", io_oeb, 38'h3FFFFFFFFF);
        resetb = 1'b1;
        cyc(1);
        chk("resume_run", la_data_out[20:0], 21'h120000);
        cyc(1);
        chk("resume_step", la_data_out[20:0], 21'h120002);
        chk("resume_oeb", io_oeb, 38'h3F0000FFFF);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
